// File: rtl/vproc_fpu_wbpack.sv
// ---------------------------------------------------------------------------
// vproc_fpu_wbpack
//
// Receiving end of the FPU result pipe. Consecutive FPU_OP_W-bit result beats
// are staged and packed into one VREG_W-bit vector register write (with
// per-byte enables). The write is issued on a valid/ready port towards the
// register-file write arbiter. Reduction beats are dropped except the last
// one, whose 32-bit scalar is written to element 0 of the destination.
//
// Optional feature macro: VPROC_FPU_WB_FFLAGS_EN
//   defined   : per-lane fpnew status flags of accepted beats are OR-ed into an
//               accumulator and reported on the last beat of an instruction.
//   undefined : in_status_i is ignored, fflags_o / fflags_valid_o stay 0.
//
// Ports
//   clk_i, async_rst_ni, sync_rst_ni   clock, async reset, sync flush (act. low)
//   in_valid_i / in_ready_o            result beat handshake
//   in_res_i, in_mask_i                beat data and byte enables
//   in_vaddr_i, in_last_i, in_red_i    destination, last beat, reduction flag
//   in_status_i                        5 status flags per 32-bit lane
//   wr_valid_o / wr_ready_i            register write handshake
//   wr_addr_o, wr_data_o, wr_be_o      register write payload
//   fflags_valid_o, fflags_o           accumulated flags (NV,DZ,OF,UF,NX)
// ---------------------------------------------------------------------------
module vproc_fpu_wbpack #(
  parameter int unsigned FPU_OP_W = 64,
  parameter int unsigned VREG_W   = 128
) (
  input  logic                       clk_i,
  input  logic                       async_rst_ni,
  input  logic                       sync_rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [FPU_OP_W-1:0]        in_res_i,
  input  logic [FPU_OP_W/8-1:0]      in_mask_i,
  input  logic [4:0]                 in_vaddr_i,
  input  logic                       in_last_i,
  input  logic                       in_red_i,
  input  logic [5*FPU_OP_W/32-1:0]   in_status_i,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [4:0]                 wr_addr_o,
  output logic [VREG_W-1:0]          wr_data_o,
  output logic [VREG_W/8-1:0]        wr_be_o,
  output logic                       fflags_valid_o,
  output logic [4:0]                 fflags_o
);

  localparam int unsigned BEATS = VREG_W / FPU_OP_W;
  localparam int unsigned BE_W  = FPU_OP_W / 8;
  localparam int unsigned VBE_W = VREG_W / 8;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // staging state
  logic [CNT_W-1:0]                 cnt_r;
  logic [BEATS-1:0][FPU_OP_W-1:0]   stage_data_r;
  logic [BEATS-1:0][BE_W-1:0]       stage_mask_r;
  logic [4:0]                       addr_r;

  // write port registers
  logic                             wr_valid_r;
  logic [4:0]                       wr_addr_r;
  logic [VREG_W-1:0]                wr_data_r;
  logic [VBE_W-1:0]                 wr_be_r;

  // combinational helpers
  logic                             accept_s;
  logic                             complete_s;
  logic                             red_last_s;
  logic [BEATS-1:0][FPU_OP_W-1:0]   merged_data_s;
  logic [BEATS-1:0][BE_W-1:0]       merged_mask_s;
  logic [4:0]                       grp_addr_s;
  logic [VREG_W-1:0]                red_data_s;
  logic [VBE_W-1:0]                 red_be_s;

  // The write register can take a new result while its current one drains.
  assign in_ready_o = ~wr_valid_r | wr_ready_i;
  assign accept_s   = in_valid_i & in_ready_o;
  // A group closes on the last slot or on the last beat of the instruction.
  assign complete_s = accept_s & ~in_red_i & ((cnt_r == CNT_LAST) | in_last_i);
  assign red_last_s = accept_s & in_red_i & in_last_i;

  assign red_data_s = {{(VREG_W-32){1'b0}}, in_res_i[31:0]};
  assign red_be_s   = {{(VBE_W-4){1'b0}}, 4'hF};

  // Staged group with the current beat merged into slot cnt; the address comes
  // straight from the input when the beat opens a new group.
  always_comb begin
    merged_data_s        = stage_data_r;
    merged_mask_s        = stage_mask_r;
    merged_data_s[cnt_r] = in_res_i;
    merged_mask_s[cnt_r] = in_mask_i;
    if (cnt_r == CNT_ZERO) begin
      grp_addr_s = in_vaddr_i;
    end else begin
      grp_addr_s = addr_r;
    end
  end

  // Beat staging: slot counter, staged data/mask and latched group address.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      cnt_r        <= CNT_ZERO;
      stage_data_r <= '0;
      stage_mask_r <= '0;
      addr_r       <= 5'd0;
    end else if (!sync_rst_ni) begin
      cnt_r        <= CNT_ZERO;
      stage_data_r <= '0;
      stage_mask_r <= '0;
      addr_r       <= 5'd0;
    end else if (accept_s && !in_red_i) begin
      if (cnt_r == CNT_ZERO) begin
        addr_r <= in_vaddr_i;
      end
      if (complete_s) begin
        // slots left unfilled by a short group must not enable any byte
        cnt_r        <= CNT_ZERO;
        stage_mask_r <= '0;
      end else begin
        cnt_r               <= cnt_r + CNT_ONE;
        stage_data_r[cnt_r] <= in_res_i;
        stage_mask_r[cnt_r] <= in_mask_i;
      end
    end
  end

  // Write request register: loads on group completion or a reduction's final
  // beat, holds while stalled, and drops after the handshake.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 5'd0;
      wr_data_r  <= '0;
      wr_be_r    <= '0;
    end else if (!sync_rst_ni) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 5'd0;
      wr_data_r  <= '0;
      wr_be_r    <= '0;
    end else if (complete_s) begin
      wr_valid_r <= 1'b1;
      wr_addr_r  <= grp_addr_s;
      wr_data_r  <= merged_data_s;
      wr_be_r    <= merged_mask_s;
    end else if (red_last_s) begin
      wr_valid_r <= 1'b1;
      wr_addr_r  <= in_vaddr_i;
      wr_data_r  <= red_data_s;
      wr_be_r    <= red_be_s;
    end else if (wr_ready_i) begin
      wr_valid_r <= 1'b0;
    end
  end

  assign wr_valid_o = wr_valid_r;
  assign wr_addr_o  = wr_addr_r;
  assign wr_data_o  = wr_data_r;
  assign wr_be_o    = wr_be_r;

`ifdef VPROC_FPU_WB_FFLAGS_EN
  localparam int unsigned LANES = FPU_OP_W / 32;

  logic [4:0] acc_r;
  logic [4:0] fflags_r;
  logic       fflags_valid_r;
  logic [4:0] beat_flags_s;

  // Flags contributed by one beat: lanes with any enabled byte, or lane 0 only
  // for reductions (their scalar always lives in lane 0).
  function automatic logic [4:0] beat_flags(input logic [5*LANES-1:0] status,
                                            input logic [BE_W-1:0]    mask,
                                            input logic               red);
    logic [4:0] f;
    f = 5'b00000;
    if (red) begin
      f = status[4:0];
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (|mask[4*l +: 4]) begin
          f = f | status[5*l +: 5];
        end else begin
          f = f;
        end
      end
    end
    return f;
  endfunction

  assign beat_flags_s = beat_flags(in_status_i, in_mask_i, in_red_i);

  // Flag accumulator; reports and clears on the instruction's last beat.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      acc_r          <= 5'b00000;
      fflags_r       <= 5'b00000;
      fflags_valid_r <= 1'b0;
    end else if (!sync_rst_ni) begin
      acc_r          <= 5'b00000;
      fflags_r       <= 5'b00000;
      fflags_valid_r <= 1'b0;
    end else begin
      fflags_valid_r <= 1'b0;
      if (accept_s) begin
        if (in_last_i) begin
          fflags_r       <= acc_r | beat_flags_s;
          fflags_valid_r <= 1'b1;
          acc_r          <= 5'b00000;
        end else begin
          acc_r <= acc_r | beat_flags_s;
        end
      end
    end
  end

  assign fflags_o       = fflags_r;
  assign fflags_valid_o = fflags_valid_r;
`else
  logic unused_status_s;
  assign unused_status_s = ^in_status_i;
  assign fflags_o        = 5'b00000;
  assign fflags_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_vproc_fpu_wbpack.sv
// Self-checking bench for vproc_fpu_wbpack (FPU_OP_W=64, VREG_W=128).
// A transaction-level model (beat queue per group, expected-write queue and a
// flag accumulator) predicts the DUT behaviour every cycle.
module tb_vproc_fpu_wbpack;
  localparam int FPU_OP_W = 64;
  localparam int VREG_W   = 128;
  localparam int BEATS    = VREG_W / FPU_OP_W;
  localparam int VBE_W    = VREG_W / 8;

  logic                 clk = 1'b0;
  logic                 async_rst_ni, sync_rst_ni;
  logic                 in_valid, in_ready;
  logic [FPU_OP_W-1:0]  in_res;
  logic [7:0]           in_mask;
  logic [4:0]           in_vaddr;
  logic                 in_last, in_red;
  logic [9:0]           in_status;
  logic                 wr_valid, wr_ready;
  logic [4:0]           wr_addr;
  logic [VREG_W-1:0]    wr_data;
  logic [VBE_W-1:0]     wr_be;
  logic                 fflags_valid;
  logic [4:0]           fflags;

  vproc_fpu_wbpack #(.FPU_OP_W(FPU_OP_W), .VREG_W(VREG_W)) dut (
    .clk_i(clk), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_res_i(in_res),
    .in_mask_i(in_mask), .in_vaddr_i(in_vaddr), .in_last_i(in_last),
    .in_red_i(in_red), .in_status_i(in_status), .wr_valid_o(wr_valid),
    .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_be_o(wr_be), .fflags_valid_o(fflags_valid), .fflags_o(fflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        addr;
    logic [VREG_W-1:0] data;
    logic [VBE_W-1:0]  be;
    logic [VBE_W-1:0]  care;
  } wr_t;
  typedef struct {
    logic [FPU_OP_W-1:0] res;
    logic [7:0]          mask;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // model state
  wr_t         exp_q[$];
  beat_t       grp_q[$];
  logic [4:0]  grp_addr;
  bit          wv_exp = 1'b0;
  logic [4:0]  acc_m = 5'd0;
  bit          ff_pulse_exp = 1'b0;
  logic [4:0]  ff_exp = 5'd0;
  bit          stall_prev = 1'b0;
  logic [4:0]  p_addr;
  logic [VREG_W-1:0] p_data;
  logic [VBE_W-1:0]  p_be;

  // per-cycle samples
  bit s_wv, s_ir, s_acc, s_ffv;
  logic [4:0] s_addr, s_ff;
  logic [VREG_W-1:0] s_data;
  logic [VBE_W-1:0] s_be;

  function automatic logic [VREG_W-1:0] bytes_to_bits(input logic [VBE_W-1:0] b);
    logic [VREG_W-1:0] r;
    for (int i = 0; i < VBE_W; i++) r[8*i +: 8] = {8{b[i]}};
    return r;
  endfunction

  function automatic logic [4:0] model_flags(input logic [9:0] st, input logic [7:0] m, input bit red);
    logic [4:0] f = 5'd0;
    for (int lane = 0; lane < 2; lane++)
      if ((red && lane == 0) || (!red && m[4*lane +: 4] != 4'h0)) f = f | st[5*lane +: 5];
    return f;
  endfunction

  task automatic set_beat(input bit v, input logic [63:0] r, input logic [7:0] m,
                          input logic [4:0] a, input bit l, input bit rd, input logic [9:0] st);
    in_valid = v; in_res = r; in_mask = m; in_vaddr = a;
    in_last = l; in_red = rd; in_status = st;
  endtask

  // One clock cycle: sample outputs just before the rising edge, compare with
  // the model, then advance the model with this cycle's inputs.
  task automatic cycle();
    wr_t w;
    bit  nxt_wv;
    logic [VREG_W-1:0] cm;
    logic [4:0] bf;
    #4;
    s_wv = wr_valid; s_ir = in_ready; s_addr = wr_addr; s_data = wr_data;
    s_be = wr_be; s_ffv = fflags_valid; s_ff = fflags;

    checks++;
    if (s_wv !== wv_exp) begin errors++; $display("FAIL wr_valid: got %0b expected %0b", s_wv, wv_exp); end
    checks++;
    if (s_ir !== (!wv_exp || wr_ready)) begin errors++; $display("FAIL in_ready: got %0b expected %0b", s_ir, (!wv_exp || wr_ready)); end
`ifdef VPROC_FPU_WB_FFLAGS_EN
    checks++;
    if (s_ffv !== ff_pulse_exp) begin errors++; $display("FAIL fflags_valid: got %0b expected %0b", s_ffv, ff_pulse_exp); end
    if (ff_pulse_exp) begin
      checks++;
      if (s_ff !== ff_exp) begin errors++; $display("FAIL fflags: got %05b expected %05b", s_ff, ff_exp); end
    end
`else
    checks++;
    if (s_ffv !== 1'b0 || s_ff !== 5'd0) begin errors++; $display("FAIL fflags_off: got %0b/%05b expected 0/00000", s_ffv, s_ff); end
`endif
    if (stall_prev) begin
      checks++;
      if (s_addr !== p_addr || s_data !== p_data || s_be !== p_be) begin
        errors++; $display("FAIL wr_stable: got %0h/%0h/%0h expected %0h/%0h/%0h", s_addr, s_data, s_be, p_addr, p_data, p_be);
      end
    end

    s_acc = in_valid && (!wv_exp || wr_ready) && sync_rst_ni;
    ff_pulse_exp = 1'b0;
    if (!sync_rst_ni) begin
      grp_q.delete(); exp_q.delete();
      wv_exp = 1'b0; acc_m = 5'd0; stall_prev = 1'b0;
    end else begin
      if (wv_exp && wr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wr_unexpected: got write addr %0d expected none", s_addr);
        end else begin
          w = exp_q.pop_front();
          cm = bytes_to_bits(w.care);
          if (s_addr !== w.addr || (s_data & cm) !== (w.data & cm) || s_be !== w.be) begin
            errors++; $display("FAIL wr_payload: got %0d/%0h/%0h expected %0d/%0h/%0h", s_addr, s_data & cm, s_be, w.addr, w.data & cm, w.be);
          end
        end
      end
      stall_prev = wv_exp && !wr_ready;
      p_addr = s_addr; p_data = s_data; p_be = s_be;
      nxt_wv = wv_exp && !wr_ready;
      if (s_acc) begin
        bf = model_flags(in_status, in_mask, in_red);
        if (in_last) begin ff_exp = acc_m | bf; ff_pulse_exp = 1'b1; acc_m = 5'd0; end
        else acc_m = acc_m | bf;
        if (in_red) begin
          if (in_last) begin
            w.addr = in_vaddr; w.data = {96'd0, in_res[31:0]};
            w.be = 16'h000F; w.care = 16'hFFFF;
            exp_q.push_back(w); nxt_wv = 1'b1;
          end
        end else begin
          if (grp_q.size() == 0) grp_addr = in_vaddr;
          grp_q.push_back('{res: in_res, mask: in_mask});
          if (grp_q.size() == BEATS || in_last) begin
            w.addr = grp_addr; w.data = '0; w.be = '0;
            for (int i = 0; i < grp_q.size(); i++) begin
              w.data[64*i +: 64] = grp_q[i].res;
              w.be[8*i +: 8] = grp_q[i].mask;
            end
            w.care = w.be;
            exp_q.push_back(w); grp_q.delete(); nxt_wv = 1'b1;
          end
        end
      end
      wv_exp = nxt_wv;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    async_rst_ni = 1'b0; sync_rst_ni = 1'b1; wr_ready = 1'b1;
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0);
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (wr_valid !== 1'b0 || wr_addr !== 5'd0 || wr_data !== '0 || wr_be !== '0 ||
        fflags_valid !== 1'b0 || fflags !== 5'd0) begin
      errors++; $display("FAIL reset: got %0b/%0h/%0h/%0h/%0b/%0h expected all 0", wr_valid, wr_addr, wr_data, wr_be, fflags_valid, fflags);
    end
    @(negedge clk);
    async_rst_ni = 1'b1;
    cycle(); cycle();
  endtask

  task automatic test_two_beats();
    wr_ready = 1'b1;
    set_beat(1, 64'h1111111111111111, 8'hFF, 5'd3, 0, 0, 10'd0); cycle();
    set_beat(1, 64'h2222222222222222, 8'hFF, 5'd3, 1, 0, 10'd0); cycle();
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0); cycle();
    checks++;
    if (s_wv !== 1'b1 || s_addr !== 5'd3 || s_be !== 16'hFFFF ||
        s_data !== {64'h2222222222222222, 64'h1111111111111111}) begin
      errors++; $display("FAIL two_beats: got %0b/%0d/%0h/%0h expected 1/3/ffff/2222..1111", s_wv, s_addr, s_be, s_data);
    end
    cycle();
  endtask

  task automatic test_single_last();
    logic [63:0] r = 64'hDEADBEEF_CAFEF00D;
    wr_ready = 1'b1;
    set_beat(1, r, 8'h0F, 5'd9, 1, 0, 10'd0); cycle();
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0); cycle();
    checks++;
    if (s_wv !== 1'b1 || s_addr !== 5'd9 || s_be !== 16'h000F || s_data[31:0] !== r[31:0]) begin
      errors++; $display("FAIL single_last: got %0b/%0d/%0h/%0h expected 1/9/000f/%0h", s_wv, s_addr, s_be, s_data[31:0], r[31:0]);
    end
    set_beat(1, 64'h0123456789ABCDEF, 8'hFF, 5'd10, 1, 0, 10'd0); cycle();
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0); cycle();
    checks++;
    if (s_be !== 16'h00FF || s_data[63:0] !== 64'h0123456789ABCDEF || s_addr !== 5'd10) begin
      errors++; $display("FAIL slot_restart: got %0d/%0h/%0h expected 10/00ff/0123456789abcdef", s_addr, s_be, s_data[63:0]);
    end
    cycle();
  endtask

  task automatic test_backpressure();
    wr_ready = 1'b0;
    set_beat(1, 64'hAAAA5555AAAA5555, 8'hFF, 5'd5, 1, 0, 10'd0); cycle();
    set_beat(1, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 5'd6, 1, 0, 10'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_ir !== 1'b0 || s_acc || s_wv !== 1'b1 || s_addr !== 5'd5) begin
        errors++; $display("FAIL stall_%0d: got ready %0b valid %0b addr %0d expected 0/1/5", i, s_ir, s_wv, s_addr);
      end
    end
    wr_ready = 1'b1; cycle();
    checks++;
    if (s_ir !== 1'b1 || !s_acc) begin errors++; $display("FAIL drain_refill: got ready %0b expected 1", s_ir); end
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0); cycle();
    checks++;
    if (s_wv !== 1'b1 || s_addr !== 5'd6) begin errors++; $display("FAIL refill_write: got %0b/%0d expected 1/6", s_wv, s_addr); end
    cycle();
  endtask

  task automatic test_reduction();
    int writes = 0;
    wr_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_beat(1, (b == 3) ? 64'hFFFF00003F800000 : {$urandom, $urandom}, 8'hFF, 5'd7, b == 3, 1, 10'd0);
      cycle();
      if (s_wv) writes++;
    end
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (s_wv) begin
        writes++;
        checks++;
        if (s_addr !== 5'd7 || s_data !== {96'd0, 32'h3F800000} || s_be !== 16'h000F) begin
          errors++; $display("FAIL red_write: got %0d/%0h/%0h expected 7/3f800000/000f", s_addr, s_data, s_be);
        end
      end
    end
    checks++;
    if (writes != 1) begin errors++; $display("FAIL red_count: got %0d expected 1", writes); end
  endtask

  task automatic test_sync_flush();
    wr_ready = 1'b1;
    set_beat(1, 64'h9999999999999999, 8'hFF, 5'd2, 0, 0, 10'h3FF); cycle();
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0);
    sync_rst_ni = 1'b0; cycle(); sync_rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_wv !== 1'b0 || s_addr !== 5'd0 || s_be !== '0 || s_data !== '0) begin
        errors++; $display("FAIL flush_%0d: got %0b/%0d/%0h expected 0/0/0", i, s_wv, s_addr, s_be);
      end
    end
    set_beat(1, 64'h4444444444444444, 8'hFF, 5'd4, 0, 0, 10'd0); cycle();
    set_beat(1, 64'h5555555555555555, 8'h3C, 5'd4, 1, 0, 10'd0); cycle();
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0); cycle();
    checks++;
    if (s_addr !== 5'd4 || s_data[63:0] !== 64'h4444444444444444 || s_be !== 16'h3CFF) begin
      errors++; $display("FAIL flush_restart: got %0d/%0h/%0h expected 4/4444444444444444/3cff", s_addr, s_data[63:0], s_be);
    end
    cycle();
  endtask

  task automatic test_fflags();
    wr_ready = 1'b1;
    set_beat(1, 64'h1, 8'hF0, 5'd1, 0, 0, {5'b00001, 5'b10000}); cycle();
    set_beat(1, 64'h2, 8'h0F, 5'd1, 1, 0, {5'b00010, 5'b00100}); cycle();
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0); cycle();
`ifdef VPROC_FPU_WB_FFLAGS_EN
    checks++;
    if (s_ffv !== 1'b1 || s_ff !== 5'b00101) begin errors++; $display("FAIL fflags_example: got %0b/%05b expected 1/00101", s_ffv, s_ff); end
    cycle();
    checks++;
    if (s_ffv !== 1'b0) begin errors++; $display("FAIL fflags_pulse: got %0b expected 0", s_ffv); end
`else
    checks++;
    if (s_ffv !== 1'b0 || s_ff !== 5'd0) begin errors++; $display("FAIL fflags_disabled: got %0b/%05b expected 0/00000", s_ffv, s_ff); end
    cycle();
`endif
  endtask

  task automatic test_random();
    int cyc = 0;
    int nb;
    bit rd, done;
    logic [4:0] va;
    logic [63:0] r;
    logic [7:0] m;
    logic [9:0] st;
    while (cyc < 1500) begin
      if ($urandom_range(0, 15) == 0) begin
        set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0);
        sync_rst_ni = 1'b0; cycle(); sync_rst_ni = 1'b1; cyc++;
      end else begin
        rd = ($urandom_range(0, 3) == 0);
        nb = rd ? $urandom_range(1, 4) : $urandom_range(1, 2 * BEATS + 1);
        va = 5'($urandom);
        for (int b = 0; b < nb; b++) begin
          r = {$urandom, $urandom};
          m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
          st = 10'($urandom);
          done = 1'b0;
          for (int t = 0; t < 50 && !done; t++) begin
            wr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) set_beat(0, r, m, va, b == nb - 1, rd, st);
            else set_beat(1, r, m, va, b == nb - 1, rd, st);
            cycle(); cyc++;
            done = s_acc;
          end
          checks++;
          if (!done) begin errors++; $display("FAIL rand_timeout: got no accept expected accept within 50 cycles"); end
        end
      end
    end
    set_beat(0, 64'd0, 8'd0, 5'd0, 0, 0, 10'd0);
    wr_ready = 1'b1;
    for (int i = 0; i < 10 && (wv_exp || exp_q.size() != 0); i++) cycle();
    cycle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_two_beats();
    test_single_last();
    test_backpressure();
    test_reduction();
    test_sync_flush();
    test_fflags();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
